// File: rtl/fb_scanout.sv
// fb_scanout: VGA scanout of a 4R4G4B framebuffer with 2x2 pixel replication.
// The pixel rate is the system clock divided by CLK_DIV; the framebuffer is
// read through a synchronous port (data one clock after the address).
// Optional macro FB_DOUBLE_BUF_EN: adds a second display bank that flips at
// vblank entry on request (address grows to 18 bits, bank in the MSB).
module fb_scanout #(
   parameter int CLK_DIV = 4,
   parameter int FB_W    = 320,
   parameter int FB_H    = 240,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic        i_clk,
   input  logic        i_rst,
`ifdef FB_DOUBLE_BUF_EN
   input  logic        i_swap_req,
   output logic        o_swap_ack,
   output logic        o_fb_bank,
   output logic [17:0] o_fb_r_addr,
`else
   output logic [16:0] o_fb_r_addr,
`endif
   input  logic [11:0] i_fb_r_data,
   output logic [11:0] o_rgb,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic        o_vblank,
   output logic        o_frame_start
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int DW    = $clog2(CLK_DIV);
   localparam int AW    = 17;

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_VIS_C   = HW'(H_VIS);
   localparam logic [HW-1:0] HS_FIRST  = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] HS_LAST   = HW'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_VIS_C   = VW'(V_VIS);
   localparam logic [VW-1:0] V_VIS_M1  = VW'(V_VIS - 1);
   localparam logic [VW-1:0] VS_FIRST  = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] VS_LAST   = VW'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [AW-1:0] FB_W_A    = AW'(FB_W);
   localparam logic [AW-1:0] FB_LAST_A = AW'(FB_W * FB_H - 1);

   logic [DW-1:0] div_cnt_r;
   logic [HW-1:0] h_cnt_r;
   logic [VW-1:0] v_cnt_r;
   logic [AW-1:0] row_base_r;

   logic          tick_s;
   logic          line_end_s;
   logic [HW-1:0] h_nxt_s;
   logic [VW-1:0] v_nxt_s;
   logic [AW-1:0] row_base_nxt_s;
   logic [AW-1:0] addr_nxt_s;
   logic          vis_cur_s;
   logic          vis_nxt_s;
   logic          addr_upd_s;
   logic          hs_low_s;
   logic          vs_low_s;
   logic          frame_wrap_s;

   // Next raster position, next row base (no multiplier) and sync decode
   always_comb begin
      tick_s     = (div_cnt_r == DIV_LAST);
      line_end_s = (h_cnt_r == H_LAST);

      if (line_end_s) begin
         h_nxt_s = '0;
      end else begin
         h_nxt_s = h_cnt_r + HW'(1);
      end

      if (!line_end_s) begin
         v_nxt_s = v_cnt_r;
      end else if (v_cnt_r == V_LAST) begin
         v_nxt_s = '0;
      end else begin
         v_nxt_s = v_cnt_r + VW'(1);
      end

      // Two screen lines share one source row: step the base after odd lines
      if (line_end_s && (v_cnt_r == V_LAST)) begin
         row_base_nxt_s = '0;
      end else if (line_end_s && v_cnt_r[0] && (v_cnt_r < V_VIS_M1)) begin
         row_base_nxt_s = row_base_r + FB_W_A;
      end else begin
         row_base_nxt_s = row_base_r;
      end

      vis_cur_s    = (h_cnt_r < H_VIS_C) && (v_cnt_r < V_VIS_C);
      vis_nxt_s    = (h_nxt_s < H_VIS_C) && (v_nxt_s < V_VIS_C);
      addr_nxt_s   = row_base_nxt_s + AW'(h_nxt_s >> 1'b1);
      // Defensive bound: never present an address past the framebuffer
      addr_upd_s   = tick_s && vis_nxt_s && (addr_nxt_s <= FB_LAST_A);
      hs_low_s     = (h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST);
      vs_low_s     = (v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST);
      frame_wrap_s = tick_s && line_end_s && (v_cnt_r == V_LAST);
   end

   // Pixel-rate divider and raster counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_cnt_r  <= '0;
         h_cnt_r    <= '0;
         v_cnt_r    <= '0;
         row_base_r <= '0;
      end else if (tick_s) begin
         div_cnt_r  <= '0;
         h_cnt_r    <= h_nxt_s;
         v_cnt_r    <= v_nxt_s;
         row_base_r <= row_base_nxt_s;
      end else begin
         div_cnt_r  <= div_cnt_r + DW'(1);
      end
   end

   // Registered video outputs; the read address is set up one pixel ahead
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_fb_r_addr   <= '0;
         o_rgb         <= 12'h000;
         o_hsync       <= 1'b1;
         o_vsync       <= 1'b1;
         o_de          <= 1'b0;
         o_vblank      <= 1'b0;
         o_frame_start <= 1'b0;
      end else begin
         o_frame_start <= frame_wrap_s;
         if (tick_s) begin
            o_de     <= vis_cur_s;
            o_rgb    <= vis_cur_s ? i_fb_r_data : 12'h000;
            o_hsync  <= !hs_low_s;
            o_vsync  <= !vs_low_s;
            o_vblank <= (v_nxt_s >= V_VIS_C);
         end else begin
            o_de     <= o_de;
         end
         if (addr_upd_s) begin
`ifdef FB_DOUBLE_BUF_EN
            o_fb_r_addr <= {o_fb_bank, addr_nxt_s};
`else
            o_fb_r_addr <= addr_nxt_s;
`endif
         end else begin
            o_fb_r_addr <= o_fb_r_addr;
         end
      end
   end

`ifdef FB_DOUBLE_BUF_EN
   logic swap_evt_s;
   logic swap_pend_r;

   // Vblank entry: the tick on which v_cnt becomes V_VIS
   always_comb begin
      swap_evt_s = tick_s && line_end_s && (v_nxt_s == V_VIS_C);
   end

   // Sticky swap request, served (bank flip + ack pulse) at vblank entry
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         swap_pend_r <= 1'b0;
         o_fb_bank   <= 1'b0;
         o_swap_ack  <= 1'b0;
      end else if (swap_evt_s && (swap_pend_r || i_swap_req)) begin
         swap_pend_r <= 1'b0;
         o_fb_bank   <= !o_fb_bank;
         o_swap_ack  <= 1'b1;
      end else begin
         swap_pend_r <= swap_pend_r || i_swap_req;
         o_fb_bank   <= o_fb_bank;
         o_swap_ack  <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard bench for fb_scanout. A full-size instance checks
// the first lines of real 640x480 timing; a reduced-geometry instance runs
// whole frames (vsync, vblank, frame start, mid-frame reset, bank swap).
module tb_fb_scanout;

`ifdef FB_DOUBLE_BUF_EN
   localparam int AW = 18;
`else
   localparam int AW = 17;
`endif
   localparam int B_DIV = 4;
   localparam int S_DIV = 2;
   localparam int S_FRAME = 15 * 10 * S_DIV;   // 300 clocks per small frame

   typedef struct { logic de; logic [11:0] rgb; logic hs; logic vs; logic vb; } exp_t;
   typedef struct { int pix; logic [11:0] rgb; } dir_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic b_rst = 1'b1, s_rst = 1'b1;
   logic [AW-1:0] b_addr, s_addr;
   logic [11:0] b_data, s_data, b_rgb, s_rgb;
   logic b_hs, b_vs, b_de, b_vb, b_fs;
   logic s_hs, s_vs, s_de, s_vb, s_fs;
`ifdef FB_DOUBLE_BUF_EN
   logic b_swap = 1'b0, s_swap = 1'b0;
   logic b_ack, b_bank, s_ack, s_bank;
`endif

   int n_chk = 0, n_fail = 0;
   int b_cyc = 0, s_cyc = 0, cyc_g = 0;
   int s_ack_n = 0;
   int b_hs_per_n = 0;
   exp_t b_q[$], s_q[$];
   dir_t b_dq[$], s_dq[$];

   fb_scanout u_big (
      .i_clk(clk), .i_rst(b_rst),
`ifdef FB_DOUBLE_BUF_EN
      .i_swap_req(b_swap), .o_swap_ack(b_ack), .o_fb_bank(b_bank),
`endif
      .o_fb_r_addr(b_addr), .i_fb_r_data(b_data), .o_rgb(b_rgb),
      .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_vblank(b_vb),
      .o_frame_start(b_fs));

   fb_scanout #(.CLK_DIV(S_DIV), .FB_W(4), .FB_H(3),
                .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_small (
      .i_clk(clk), .i_rst(s_rst),
`ifdef FB_DOUBLE_BUF_EN
      .i_swap_req(s_swap), .o_swap_ack(s_ack), .o_fb_bank(s_bank),
`endif
      .o_fb_r_addr(s_addr), .i_fb_r_data(s_data), .o_rgb(s_rgb),
      .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de), .o_vblank(s_vb),
      .o_frame_start(s_fs));

   // Framebuffer models: fb[idx] = idx[11:0], one clock read latency
   always @(posedge clk) begin
      b_data <= b_addr[11:0];
      s_data <= s_addr[11:0];
   end

   // Clocks since each instance's last reset edge
   always @(posedge clk) begin
      cyc_g <= cyc_g + 1;
      b_cyc <= b_rst ? 0 : b_cyc + 1;
      s_cyc <= s_rst ? 0 : s_cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic bound_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   // Reference output of screen pixel index p (raster order from reset)
   function automatic exp_t pix_model(input int p, input int fbw, input int hv, input int hs0,
                                      input int hs1, input int ht, input int vv, input int vs0,
                                      input int vs1, input int vt);
      exp_t e;
      int h, v, vn;
      h  = p % ht;
      v  = (p / ht) % vt;
      vn = ((p + 1) / ht) % vt;
      e.de  = (h < hv) && (v < vv);
      e.rgb = e.de ? 12'((v / 2) * fbw + h / 2) : 12'h000;
      e.hs  = !(h >= hs0 && h <= hs1);
      e.vs  = !(v >= vs0 && v <= vs1);
      e.vb  = (vn >= vv);
      return e;
   endfunction

   task automatic wait_s_cyc(input int n);
      int guard = 0;
      while (s_cyc != n && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (s_cyc != n) bound_fail($sformatf("reach small cycle %0d", n));
   endtask

   // Monitor, full-size instance: one scoreboard entry per pixel period
   always @(negedge clk) begin
      int p;
      exp_t e;
      if (b_cyc > 0 && b_cyc % B_DIV == 0) begin
         p = b_cyc / B_DIV - 1;
         if (b_q.size() > 0) begin
            e = b_q.pop_front();
            chk($sformatf("big de p%0d", p), 32'(b_de), 32'(e.de));
            chk($sformatf("big rgb p%0d", p), 32'(b_rgb), 32'(e.rgb));
            chk($sformatf("big hsync p%0d", p), 32'(b_hs), 32'(e.hs));
            chk($sformatf("big vsync p%0d", p), 32'(b_vs), 32'(e.vs));
            chk($sformatf("big vblank p%0d", p), 32'(b_vb), 32'(e.vb));
         end
         if (b_dq.size() > 0 && b_dq[0].pix == p) begin
            chk($sformatf("big directed rgb p%0d", p), 32'(b_rgb), 32'(b_dq[0].rgb));
            void'(b_dq.pop_front());
         end
         if (b_de) chk($sformatf("big addr in range p%0d", p), 32'(b_addr[16:0] <= 17'd76799), 32'd1);
      end
      if (b_fs) bound_fail("big frame_start too early");
   end

   // Monitor, reduced instance: scoreboard, last-pixel address, frame start
   always @(negedge clk) begin
      int p;
      exp_t e;
      if (s_cyc > 0 && s_cyc % S_DIV == 0) begin
         p = s_cyc / S_DIV - 1;
         if (s_q.size() > 0) begin
            e = s_q.pop_front();
            chk($sformatf("small de p%0d", p), 32'(s_de), 32'(e.de));
            chk($sformatf("small rgb p%0d", p), 32'(s_rgb), 32'(e.rgb));
            chk($sformatf("small hsync p%0d", p), 32'(s_hs), 32'(e.hs));
            chk($sformatf("small vsync p%0d", p), 32'(s_vs), 32'(e.vs));
            chk($sformatf("small vblank p%0d", p), 32'(s_vb), 32'(e.vb));
         end
         if (s_dq.size() > 0 && s_dq[0].pix == p) begin
            chk($sformatf("small directed rgb p%0d", p), 32'(s_rgb), 32'(s_dq[0].rgb));
            void'(s_dq.pop_front());
         end
         if (p == 82) chk("small last visible addr", 32'(s_addr[16:0]), 32'd11);
         if (s_de) chk($sformatf("small addr in range p%0d", p), 32'(s_addr[16:0] <= 17'd11), 32'd1);
      end
      if (s_cyc > 0 && s_cyc % S_FRAME == 0) begin
         chk($sformatf("small frame_start at %0d", s_cyc), 32'(s_fs), 32'd1);
      end else if (s_fs) begin
         bound_fail($sformatf("small frame_start stray at %0d", s_cyc));
      end
   end

   // Horizontal sync period and low width on the full-size instance
   logic b_hs_d = 1'b1;
   int b_fall = -1;
   always @(negedge clk) begin
      if (b_hs_d === 1'b1 && b_hs === 1'b0) begin
         if (b_fall >= 0) begin
            chk("big hsync period", 32'(cyc_g - b_fall), 32'd3200);
            b_hs_per_n <= b_hs_per_n + 1;
         end
         b_fall <= cyc_g;
      end
      if (b_hs_d === 1'b0 && b_hs === 1'b1 && b_fall >= 0)
         chk("big hsync low width", 32'(cyc_g - b_fall), 32'd384);
      b_hs_d <= b_hs;
   end

`ifdef FB_DOUBLE_BUF_EN
   // Count swap acknowledges on the reduced instance
   always @(negedge clk) begin
      if (s_ack === 1'b1) s_ack_n <= s_ack_n + 1;
   end
`endif

   initial begin
      int guard;
      for (int p = 0; p < 2400; p++)
         b_q.push_back(pix_model(p, 320, 640, 656, 751, 800, 480, 490, 491, 525));
      for (int p = 0; p < 300; p++)
         s_q.push_back(pix_model(p, 4, 8, 10, 12, 15, 6, 7, 8, 10));
      b_dq.push_back('{0, 12'h000});    b_dq.push_back('{1, 12'h000});
      b_dq.push_back('{2, 12'h001});    b_dq.push_back('{639, 12'h13F});
      b_dq.push_back('{800, 12'h000});  b_dq.push_back('{801, 12'h000});
      b_dq.push_back('{1600, 12'h140}); b_dq.push_back('{2239, 12'h27F});
      s_dq.push_back('{32, 12'h005});   s_dq.push_back('{82, 12'h00B});

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset big addr", 32'(b_addr), 32'd0);
      chk("reset big rgb", 32'(b_rgb), 32'd0);
      chk("reset big hsync", 32'(b_hs), 32'd1);
      chk("reset big vsync", 32'(b_vs), 32'd1);
      chk("reset big de", 32'(b_de), 32'd0);
      chk("reset big vblank", 32'(b_vb), 32'd0);
      chk("reset big frame_start", 32'(b_fs), 32'd0);
      chk("reset small addr", 32'(s_addr), 32'd0);
      chk("reset small hsync", 32'(s_hs), 32'd1);
      chk("reset small vsync", 32'(s_vs), 32'd1);
`ifdef FB_DOUBLE_BUF_EN
      chk("reset small bank", 32'(s_bank), 32'd0);
      chk("reset small swap_ack", 32'(s_ack), 32'd0);
`endif
      b_rst = 1'b0;
      s_rst = 1'b0;

      repeat (9700) @(negedge clk);
      chk("big scoreboard drained", 32'(b_q.size()), 32'd0);
      chk("big directed drained", 32'(b_dq.size()), 32'd0);
      chk("small scoreboard drained", 32'(s_q.size()), 32'd0);
      chk("big hsync periods measured", 32'(b_hs_per_n >= 2), 32'd1);

      // Mid-frame reset on the reduced instance at h=5, v=3
      guard = 0;
      while (s_cyc % S_FRAME != 101 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (s_cyc % S_FRAME != 101) bound_fail("reach mid-frame position");
      s_rst = 1'b1;
      @(negedge clk);
      chk("midreset de", 32'(s_de), 32'd0);
      chk("midreset hsync", 32'(s_hs), 32'd1);
      chk("midreset vsync", 32'(s_vs), 32'd1);
      chk("midreset addr", 32'(s_addr), 32'd0);
      chk("midreset vblank", 32'(s_vb), 32'd0);
      s_rst = 1'b0;
      @(negedge clk);
      guard = 0;
      while (s_fs !== 1'b1 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      chk("first frame_start after reset", 32'(s_cyc), 32'(S_FRAME));

`ifdef FB_DOUBLE_BUF_EN
      // Request at v=2 of frame 1; flip expected at vblank entry (cycle 480)
      wait_s_cyc(360);
      s_swap = 1'b1;
      @(negedge clk);
      s_swap = 1'b0;
      guard = 0;
      while (s_ack !== 1'b1 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      chk("swap_ack at vblank entry", 32'(s_cyc), 32'd480);
      chk("bank after swap", 32'(s_bank), 32'd1);
      wait_s_cyc(604);
      chk("next frame addr bank bit", 32'(s_addr[17]), 32'd1);
      wait_s_cyc(1300);
      chk("single flip per request", 32'(s_ack_n), 32'd1);
      chk("bank held without request", 32'(s_bank), 32'd1);
`endif

      repeat (10) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
